mbist_fault_log: RTL

- Downstream consumer of the MBIST controller's error outputs: top_error, top_fault_addr, top_fault_bit and ebist.
- Captures each distinct failing (address, bit) cell of the 8x8 bit-addressable memory in a small log.
- When BIST completes, runs a built-in redundancy analysis. The analysis allocates one spare row and one spare column, and reports whether the array is repairable.

---
 rtl/mbist_fault_log.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mbist_fault_log.sv
// MBIST fault log: captures distinct failing cells, then runs
// a one-spare-row / one-spare-column redundancy analysis.
module mbist_fault_log #(
  parameter int ADDR_W = 3,
  parameter int BIT_W  = 3,
  parameter int DEPTH  = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              err_valid,
  input  logic [ADDR_W-1:0] err_addr,
  input  logic [BIT_W-1:0]  err_bit,
  input  logic              bist_done,
  output logic [CW-1:0]     fault_count,
  output logic              log_full,
  output logic              log_overflow,
  input  logic [IW-1:0]     rd_idx,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [BIT_W-1:0]  rd_bit,
  output logic              repair_done,
  output logic              repair_ok,
  output logic              row_used,
  output logic [ADDR_W-1:0] row_addr,
  output logic              col_used,
  output logic [BIT_W-1:0]  col_bit
);

  typedef enum logic [1:0] {
    LOG, SCAN_ROW, SCAN_COL, DONE
  } state_t;

  state_t state;

  logic [ADDR_W-1:0] log_addr [DEPTH];
  logic [BIT_W-1:0]  log_bit  [DEPTH];

  logic start_q, bist_q;
  logic start_edge, bist_edge;

  logic [IW-1:0]     idx;
  logic              seen, fail;
  logic [ADDR_W-1:0] lat_a;
  logic [BIT_W-1:0]  lat_b;

  logic              hit, log_en, ovf_set, ovf_next;
  logic [CW-1:0]     n_next;
  logic [ADDR_W-1:0] cur_addr, cand_row, lat_a_n;
  logic [BIT_W-1:0]  cur_bit, cand_col, lat_b_n;
  logic              other, seen_n, fail_n, last;

  assign start_edge = start & ~start_q;
  assign bist_edge  = bist_done & ~bist_q;

  assign log_full = (fault_count == CW'(DEPTH));
  assign rd_valid = (CW'(rd_idx) < fault_count);
  assign rd_addr  = log_addr[rd_idx];
  assign rd_bit   = log_bit[rd_idx];

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < fault_count &&
          log_addr[i] == err_addr &&
          log_bit[i] == err_bit)
        hit = 1'b1;
    end
  end

  assign log_en  = (state == LOG) & err_valid & ~hit & ~log_full;
  assign ovf_set = (state == LOG) & err_valid & ~hit & log_full;
  assign n_next  = fault_count + CW'(log_en);
  assign ovf_next = log_overflow | ovf_set;

  // One entry per cycle; the current entry's vote is folded in here
  // so the final index can decide without an extra cycle.
  always_comb begin
    cur_addr = log_addr[idx];
    cur_bit  = log_bit[idx];
    cand_row = log_addr[0];
    cand_col = log_bit[0];
    lat_a_n  = lat_a;
    lat_b_n  = lat_b;
    fail_n   = fail;
    if (state == SCAN_ROW) begin
      other = (cur_addr != cand_row);
      if (other && !seen) lat_b_n = cur_bit;
      if (other && seen && cur_bit != lat_b) fail_n = 1'b1;
    end else begin
      other = (cur_bit != cand_col);
      if (other && !seen) lat_a_n = cur_addr;
      if (other && seen && cur_addr != lat_a) fail_n = 1'b1;
    end
    seen_n = seen | other;
    last   = (CW'(idx) == fault_count - CW'(1));
  end

  always_ff @(posedge clk) begin
    start_q <= start;
    bist_q  <= bist_done;
    if (reset || start_edge) begin
      state        <= LOG;
      fault_count  <= '0;
      log_overflow <= 1'b0;
      repair_done  <= 1'b0;
      repair_ok    <= 1'b0;
      row_used     <= 1'b0;
      row_addr     <= '0;
      col_used     <= 1'b0;
      col_bit      <= '0;
      idx          <= '0;
      seen         <= 1'b0;
      fail         <= 1'b0;
      lat_a        <= '0;
      lat_b        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        log_addr[i] <= '0;
        log_bit[i]  <= '0;
      end
    end else begin
      unique case (state)
        LOG: begin
          if (log_en) begin
            log_addr[fault_count[IW-1:0]] <= err_addr;
            log_bit[fault_count[IW-1:0]]  <= err_bit;
            fault_count <= fault_count + CW'(1);
          end
          if (ovf_set) log_overflow <= 1'b1;
          if (bist_edge) begin
            idx   <= '0;
            seen  <= 1'b0;
            fail  <= 1'b0;
            lat_a <= '0;
            lat_b <= '0;
            if (ovf_next || n_next == '0) begin
              state       <= DONE;
              repair_done <= 1'b1;
              repair_ok   <= ~ovf_next;
            end else begin
              state <= SCAN_ROW;
            end
          end
        end
        SCAN_ROW: begin
          idx   <= idx + IW'(1);
          seen  <= seen_n;
          fail  <= fail_n;
          lat_b <= lat_b_n;
          if (last) begin
            idx   <= '0;
            seen  <= 1'b0;
            fail  <= 1'b0;
            lat_a <= '0;
            if (!fail_n) begin
              state       <= DONE;
              repair_done <= 1'b1;
              repair_ok   <= 1'b1;
              row_used    <= 1'b1;
              row_addr    <= cand_row;
              col_used    <= seen_n;
              col_bit     <= lat_b_n;
            end else begin
              state <= SCAN_COL;
            end
          end
        end
        SCAN_COL: begin
          idx   <= idx + IW'(1);
          seen  <= seen_n;
          fail  <= fail_n;
          lat_a <= lat_a_n;
          if (last) begin
            state       <= DONE;
            repair_done <= 1'b1;
            repair_ok   <= ~fail_n;
            col_used    <= ~fail_n;
            col_bit     <= fail_n ? '0 : cand_col;
            row_used    <= ~fail_n & seen_n;
            row_addr    <= fail_n ? '0 : lat_a_n;
          end
        end
        DONE: begin
        end
      endcase
    end
  end

endmodule
